// File: rtl/arch_state_dumper.sv
// -----------------------------------------------------------------------------
// arch_state_dumper
//
// Architectural-state snapshot engine. A free-running saturating cycle counter
// starts at reset release. When the counter hits a programmed cycle (once per
// reset) or a manual trigger arrives while idle, the engine walks the register
// file and then data memory. It streams one word per beat over a valid/ready
// port. Each beat is tagged with its source and index. While the dump runs, the
// engine holds freeze_o high so the CPU keeps its state stable.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_n         asynchronous active-low reset
//   dump_cycle_i  cycle number for the automatic dump
//   auto_en_i     enables the automatic dump
//   trig_i        manual dump request (honoured only when idle)
//   rf_addr_o     register-file read address
//   rf_data_i     combinational register-file read data
//   dm_addr_o     data-memory word read address
//   dm_data_i     combinational data-memory read data
//   out_valid_o   beat valid
//   out_ready_i   sink ready
//   out_data_o    beat payload
//   out_tag_o     0 = register, 1 = memory
//   out_index_o   register number or memory word index
//   freeze_o      CPU hold request
//   busy_o        dump in progress
//   done_o        one-cycle pulse at dump completion
//   cycle_o       cycle counter
// -----------------------------------------------------------------------------
module arch_state_dumper #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  parameter  int NUM_MEM  = 32,
  parameter  int CNT_W    = 16,
  localparam int RA_W     = $clog2(NUM_REGS),
  localparam int MA_W     = $clog2(NUM_MEM),
  localparam int IDX_W    = (RA_W > MA_W) ? RA_W : MA_W
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  dump_cycle_i,
  input  logic              auto_en_i,
  input  logic              trig_i,
  output logic [RA_W-1:0]   rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [MA_W-1:0]   dm_addr_o,
  input  logic [DATA_W-1:0] dm_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_tag_o,
  output logic [IDX_W-1:0]  out_index_o,
  output logic              freeze_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  cycle_o
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(NUM_MEM - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cycle_q;
  logic                fired_q;
  logic                phase_q;   // 0 = walking registers, 1 = walking memory
  logic [IDX_W-1:0]    ptr_q;

  // Captured beat (output stage)
  logic                vld_p1;
  logic [DATA_W-1:0]   data_p1;
  logic                tag_p1;
  logic [IDX_W-1:0]    index_p1;

  logic auto_hit;
  logic start;
  logic accept;
  logic last_beat;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign auto_hit  = auto_en_i && (cycle_q == dump_cycle_i) && !fired_q;
  assign accept    = vld_p1 && out_ready_i;
  assign last_beat = phase_q && (ptr_q == LAST_MEM);

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    busy_o    = 1'b0;
    freeze_o  = 1'b0;
    done_o    = 1'b0;
    rf_addr_o = '0;
    dm_addr_o = '0;
    case (state_q)
      IDLE: begin
        if (auto_hit || trig_i) begin
          start   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        busy_o   = 1'b1;
        freeze_o = 1'b1;
        if (phase_q) dm_addr_o = ptr_q[MA_W-1:0];
        else         rf_addr_o = ptr_q[RA_W-1:0];
        state_d  = SEND;
      end
      SEND: begin
        busy_o   = 1'b1;
        freeze_o = 1'b1;
        if (accept) state_d = last_beat ? DONE : FETCH;
      end
      DONE: begin
        busy_o   = 1'b1;
        freeze_o = 1'b1;
        done_o   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter, trigger bookkeeping, pointer walk and beat capture
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q  <= '0;
      fired_q  <= 1'b0;
      phase_q  <= 1'b0;
      ptr_q    <= '0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      tag_p1   <= 1'b0;
      index_p1 <= '0;
    end else begin
      cycle_q <= sat_inc(cycle_q);
      // fired only latches on the auto condition, so a manual-only dump
      // leaves the pending auto dump armed.
      if (state_q == IDLE && auto_hit) fired_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q   <= '0;
            phase_q <= 1'b0;
          end
        end
        FETCH: begin
          vld_p1   <= 1'b1;
          data_p1  <= phase_q ? dm_data_i : rf_data_i;
          tag_p1   <= phase_q;
          index_p1 <= ptr_q;
        end
        SEND: begin
          if (accept) begin
            vld_p1 <= 1'b0;
            if (!phase_q && ptr_q == LAST_REG) begin
              phase_q <= 1'b1;
              ptr_q   <= '0;
            end else if (!last_beat) begin
              ptr_q <= ptr_q + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid_o = vld_p1;
  assign out_data_o  = data_p1;
  assign out_tag_o   = tag_p1;
  assign out_index_o = index_p1;
  assign cycle_o     = cycle_q;

endmodule

// File: tb/tb_arch_state_dumper.sv
// -----------------------------------------------------------------------------
// Testbench for arch_state_dumper: a default-size instance (u0) and a small
// instance (u1). Beats are collected by a monitor and compared against the
// expected register-then-memory walk built from the memory model arrays.
// -----------------------------------------------------------------------------
module tb_arch_state_dumper;

  localparam int NR0 = 32, NM0 = 32, CW0 = 16, N0 = NR0 + NM0;
  localparam int NR1 = 8,  NM1 = 4,  CW1 = 4,  N1 = NR1 + NM1;

  typedef struct packed {
    logic        tag;
    logic [7:0]  idx;
    logic [31:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- instance 0: default parameters ----------------
  logic            rst0_n, auto_en0, trig0, ready0;
  logic [CW0-1:0]  dump_cycle0, cycle0;
  logic [4:0]      rf_addr0, dm_addr0, idx0;
  logic [31:0]     rf_data0, dm_data0, data0;
  logic            valid0, tag0, freeze0, busy0, done0;
  logic [31:0]     rf0  [NR0];
  logic [31:0]     mem0 [NM0];
  bit              rnd0;

  assign rf_data0 = rf0[rf_addr0];
  assign dm_data0 = mem0[dm_addr0];

  arch_state_dumper u0 (
    .clk_i(clk), .rst_n(rst0_n), .dump_cycle_i(dump_cycle0), .auto_en_i(auto_en0),
    .trig_i(trig0), .rf_addr_o(rf_addr0), .rf_data_i(rf_data0), .dm_addr_o(dm_addr0),
    .dm_data_i(dm_data0), .out_valid_o(valid0), .out_ready_i(ready0), .out_data_o(data0),
    .out_tag_o(tag0), .out_index_o(idx0), .freeze_o(freeze0), .busy_o(busy0),
    .done_o(done0), .cycle_o(cycle0)
  );

  // ---------------- instance 1: small configuration ----------------
  logic            rst1_n, auto_en1, trig1, ready1;
  logic [CW1-1:0]  dump_cycle1, cycle1;
  logic [2:0]      rf_addr1, idx1;
  logic [1:0]      dm_addr1;
  logic [15:0]     rf_data1, dm_data1, data1;
  logic            valid1, tag1, freeze1, busy1, done1;
  logic [15:0]     rf1  [NR1];
  logic [15:0]     mem1 [NM1];

  assign rf_data1 = rf1[rf_addr1];
  assign dm_data1 = mem1[dm_addr1];

  arch_state_dumper #(.DATA_W(16), .NUM_REGS(NR1), .NUM_MEM(NM1), .CNT_W(CW1)) u1 (
    .clk_i(clk), .rst_n(rst1_n), .dump_cycle_i(dump_cycle1), .auto_en_i(auto_en1),
    .trig_i(trig1), .rf_addr_o(rf_addr1), .rf_data_i(rf_data1), .dm_addr_o(dm_addr1),
    .dm_data_i(dm_data1), .out_valid_o(valid1), .out_ready_i(ready1), .out_data_o(data1),
    .out_tag_o(tag1), .out_index_o(idx1), .freeze_o(freeze1), .busy_o(busy1),
    .done_o(done1), .cycle_o(cycle1)
  );

  // ---------------- monitors (sampled on the falling edge) ----------------
  beat_t q0[$];
  beat_t q1[$];
  int    done_cnt0, busy_cnt0, frz_cnt0, stab_err0, first_vcyc0;
  int    done_cnt1, busy_cnt1;
  bit    seen_v0;
  logic  pv0, pr0, pt0;
  logic [31:0] pd0;
  logic [4:0]  pi0;

  initial begin
    beat_t b0, b1;
    pv0 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst0_n) begin
        pv0 = 1'b0;
      end else begin
        if (pv0 && !pr0 && (!valid0 || data0 !== pd0 || tag0 !== pt0 || idx0 !== pi0))
          stab_err0++;
        if (valid0 && ready0) begin
          b0.tag = tag0; b0.idx = 8'(idx0); b0.data = data0;
          q0.push_back(b0);
        end
        if (valid0 && !seen_v0) begin
          seen_v0 = 1'b1;
          first_vcyc0 = int'(cycle0);
        end
        done_cnt0 += int'(done0);
        busy_cnt0 += int'(busy0);
        frz_cnt0  += int'(freeze0);
        pv0 = valid0; pr0 = ready0; pd0 = data0; pt0 = tag0; pi0 = idx0;
      end
      if (rst1_n) begin
        if (valid1 && ready1) begin
          b1.tag = tag1; b1.idx = 8'(idx1); b1.data = 32'(data1);
          q1.push_back(b1);
        end
        done_cnt1 += int'(done1);
        busy_cnt1 += int'(busy1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    ready0 = rnd0 ? ($urandom_range(0, 99) < 30) : 1'b1;
  endtask

  task automatic clear0();
    q0.delete();
    done_cnt0 = 0; busy_cnt0 = 0; frz_cnt0 = 0; stab_err0 = 0;
    seen_v0 = 1'b0; first_vcyc0 = -1;
  endtask

  task automatic pulse_trig0();
    trig0 = 1'b1;
    step();
    trig0 = 1'b0;
  endtask

  task automatic wait_dump0(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      step();
      if (done_cnt0 > 0 && !busy0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic fill_random0();
    for (int i = 0; i < NR0; i++) rf0[i]  = $urandom;
    for (int i = 0; i < NM0; i++) mem0[i] = $urandom;
  endtask

  task automatic fill_ramp0();
    for (int i = 0; i < NR0; i++) rf0[i]  = i;
    for (int i = 0; i < NM0; i++) mem0[i] = 100 + i;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst0_n = 1'b0; rst1_n = 1'b0;
    step(); step();
    vectors++;
    if ({valid0, data0, tag0, idx0, rf_addr0, dm_addr0, freeze0, busy0, done0, cycle0} !== '0) begin
      miscompares++;
      $display("FAIL reset_u0: got valid=%b data=%h tag=%b idx=%0d busy=%b freeze=%b done=%b cycle=%0d, expected all 0",
               valid0, data0, tag0, idx0, busy0, freeze0, done0, cycle0);
    end
    vectors++;
    if ({valid1, data1, tag1, idx1, rf_addr1, dm_addr1, freeze1, busy1, done1, cycle1} !== '0) begin
      miscompares++;
      $display("FAIL reset_u1: got valid=%b data=%h tag=%b idx=%0d busy=%b cycle=%0d, expected all 0",
               valid1, data1, tag1, idx1, busy1, cycle1);
    end
  endtask

  task automatic test_auto_dump();
    bit ok;
    fill_ramp0();
    auto_en0 = 1'b1; dump_cycle0 = 16'd30; rnd0 = 1'b0;
    clear0();
    rst0_n = 1'b1;
    wait_dump0(400, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL auto_timeout: done seen=%0d, expected completion", done_cnt0); end
    vectors++;
    if (q0.size() != N0) begin miscompares++; $display("FAIL auto_count: got %0d beats, expected %0d", q0.size(), N0); end
    for (int k = 0; k < N0 && k < q0.size(); k++) begin
      beat_t e;
      e.tag  = (k >= NR0);
      e.idx  = (k < NR0) ? 8'(k) : 8'(k - NR0);
      e.data = (k < NR0) ? rf0[k] : mem0[k - NR0];
      vectors++;
      if (q0[k] !== e) begin
        miscompares++;
        $display("FAIL auto_beat[%0d]: got tag=%0d idx=%0d data=%0d, expected tag=%0d idx=%0d data=%0d",
                 k, q0[k].tag, q0[k].idx, q0[k].data, e.tag, e.idx, e.data);
      end
    end
    vectors++;
    if (first_vcyc0 != 32) begin miscompares++; $display("FAIL auto_first_valid: got cycle %0d, expected 32", first_vcyc0); end
    vectors++;
    if (done_cnt0 != 1) begin miscompares++; $display("FAIL auto_done_pulse: got %0d done cycles, expected 1", done_cnt0); end
    vectors++;
    if (busy_cnt0 != 2 * N0 + 1) begin miscompares++; $display("FAIL auto_busy_len: got %0d, expected %0d", busy_cnt0, 2 * N0 + 1); end
    vectors++;
    if (frz_cnt0 != 2 * N0 + 1) begin miscompares++; $display("FAIL auto_freeze_len: got %0d, expected %0d", frz_cnt0, 2 * N0 + 1); end
    repeat (60) step();
    vectors++;
    if (q0.size() != N0 || done_cnt0 != 1) begin
      miscompares++;
      $display("FAIL auto_no_repeat: got %0d beats %0d done, expected %0d beats 1 done", q0.size(), done_cnt0, N0);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    fill_random0();
    rnd0 = 1'b1;
    clear0();
    pulse_trig0();
    wait_dump0(4000, ok);
    rnd0 = 1'b0;
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL bp_timeout: done seen=%0d, expected completion", done_cnt0); end
    vectors++;
    if (q0.size() != N0) begin miscompares++; $display("FAIL bp_count: got %0d beats, expected %0d", q0.size(), N0); end
    for (int k = 0; k < N0 && k < q0.size(); k++) begin
      beat_t e;
      e.tag  = (k >= NR0);
      e.idx  = (k < NR0) ? 8'(k) : 8'(k - NR0);
      e.data = (k < NR0) ? rf0[k] : mem0[k - NR0];
      vectors++;
      if (q0[k] !== e) begin
        miscompares++;
        $display("FAIL bp_beat[%0d]: got tag=%0d idx=%0d data=%h, expected tag=%0d idx=%0d data=%h",
                 k, q0[k].tag, q0[k].idx, q0[k].data, e.tag, e.idx, e.data);
      end
    end
    vectors++;
    if (stab_err0 != 0) begin miscompares++; $display("FAIL bp_stable: got %0d payload changes under stall, expected 0", stab_err0); end
    vectors++;
    if (done_cnt0 != 1) begin miscompares++; $display("FAIL bp_done_pulse: got %0d, expected 1", done_cnt0); end
    vectors++;
    if (busy_cnt0 <= 2 * N0 + 1) begin miscompares++; $display("FAIL bp_stalls: got busy %0d cycles, expected more than %0d", busy_cnt0, 2 * N0 + 1); end
  endtask

  task automatic test_trig_during_dump();
    bit ok;
    fill_random0();
    clear0();
    pulse_trig0();
    repeat (20) step();
    pulse_trig0();
    wait_dump0(400, ok);
    vectors++;
    if (ok !== 1'b1 || q0.size() != N0 || done_cnt0 != 1) begin
      miscompares++;
      $display("FAIL trig_first_dump: got ok=%0d beats=%0d done=%0d, expected 1/%0d/1", ok, q0.size(), done_cnt0, N0);
    end
    repeat (5) step();
    vectors++;
    if (busy0 !== 1'b0 || q0.size() != N0) begin
      miscompares++;
      $display("FAIL trig_not_queued: got busy=%b beats=%0d, expected busy=0 beats=%0d", busy0, q0.size(), N0);
    end
    fill_random0();
    clear0();
    pulse_trig0();
    wait_dump0(400, ok);
    vectors++;
    if (ok !== 1'b1 || q0.size() != N0 || done_cnt0 != 1) begin
      miscompares++;
      $display("FAIL trig_second_dump: got ok=%0d beats=%0d done=%0d, expected 1/%0d/1", ok, q0.size(), done_cnt0, N0);
    end
    for (int k = 0; k < N0 && k < q0.size(); k++) begin
      beat_t e;
      e.tag  = (k >= NR0);
      e.idx  = (k < NR0) ? 8'(k) : 8'(k - NR0);
      e.data = (k < NR0) ? rf0[k] : mem0[k - NR0];
      vectors++;
      if (q0[k] !== e) begin
        miscompares++;
        $display("FAIL trig_beat[%0d]: got tag=%0d idx=%0d data=%h, expected tag=%0d idx=%0d data=%h",
                 k, q0[k].tag, q0[k].idx, q0[k].data, e.tag, e.idx, e.data);
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    bit ok;
    bit reached;
    fill_ramp0();
    clear0();
    pulse_trig0();
    reached = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (q0.size() >= 10) begin reached = 1'b1; break; end
      step();
    end
    vectors++;
    if (reached !== 1'b1) begin miscompares++; $display("FAIL rst_reach_beat10: got %0d beats, expected 10", q0.size()); end
    #2 rst0_n = 1'b0;
    #1;
    vectors++;
    if ({valid0, data0, tag0, idx0, rf_addr0, dm_addr0, freeze0, busy0, done0, cycle0} !== '0) begin
      miscompares++;
      $display("FAIL rst_async: got valid=%b data=%h tag=%b idx=%0d busy=%b freeze=%b done=%b cycle=%0d, expected all 0",
               valid0, data0, tag0, idx0, busy0, freeze0, done0, cycle0);
    end
    step(); step();
    vectors++;
    if (cycle0 !== '0 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_hold: got cycle=%0d busy=%b, expected 0/0", cycle0, busy0);
    end
    clear0();
    auto_en0 = 1'b1; dump_cycle0 = 16'd30;
    rst0_n = 1'b1;
    wait_dump0(400, ok);
    vectors++;
    if (ok !== 1'b1 || first_vcyc0 != 32) begin
      miscompares++;
      $display("FAIL rst_auto_refire: got ok=%0d first valid cycle=%0d, expected 1/32", ok, first_vcyc0);
    end
    vectors++;
    if (q0.size() != N0 || done_cnt0 != 1) begin
      miscompares++;
      $display("FAIL rst_auto_count: got %0d beats %0d done, expected %0d/1", q0.size(), done_cnt0, N0);
    end
    for (int k = 0; k < N0 && k < q0.size(); k++) begin
      beat_t e;
      e.tag  = (k >= NR0);
      e.idx  = (k < NR0) ? 8'(k) : 8'(k - NR0);
      e.data = (k < NR0) ? rf0[k] : mem0[k - NR0];
      vectors++;
      if (q0[k] !== e) begin
        miscompares++;
        $display("FAIL rst_beat[%0d]: got tag=%0d idx=%0d data=%0d, expected tag=%0d idx=%0d data=%0d",
                 k, q0[k].tag, q0[k].idx, q0[k].data, e.tag, e.idx, e.data);
      end
    end
  endtask

  task automatic test_small();
    bit ok;
    for (int i = 0; i < NR1; i++) rf1[i]  = 16'($urandom);
    for (int i = 0; i < NM1; i++) mem1[i] = 16'($urandom);
    auto_en1 = 1'b1; dump_cycle1 = 4'd15;
    q1.delete(); done_cnt1 = 0; busy_cnt1 = 0;
    rst1_n = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (done_cnt1 > 0 && !busy1) begin ok = 1'b1; break; end
    end
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL small_timeout: done seen=%0d, expected completion", done_cnt1); end
    vectors++;
    if (q1.size() != N1) begin miscompares++; $display("FAIL small_count: got %0d beats, expected %0d", q1.size(), N1); end
    for (int k = 0; k < N1 && k < q1.size(); k++) begin
      beat_t e;
      e.tag  = (k >= NR1);
      e.idx  = (k < NR1) ? 8'(k) : 8'(k - NR1);
      e.data = (k < NR1) ? 32'(rf1[k]) : 32'(mem1[k - NR1]);
      vectors++;
      if (q1[k] !== e) begin
        miscompares++;
        $display("FAIL small_beat[%0d]: got tag=%0d idx=%0d data=%h, expected tag=%0d idx=%0d data=%h",
                 k, q1[k].tag, q1[k].idx, q1[k].data, e.tag, e.idx, e.data);
      end
    end
    vectors++;
    if (busy_cnt1 != 2 * N1 + 1) begin miscompares++; $display("FAIL small_busy_len: got %0d, expected %0d", busy_cnt1, 2 * N1 + 1); end
    repeat (60) step();
    vectors++;
    if (cycle1 !== 4'hF) begin miscompares++; $display("FAIL small_saturate: got cycle=%0d, expected 15", cycle1); end
    vectors++;
    if (q1.size() != N1 || done_cnt1 != 1) begin
      miscompares++;
      $display("FAIL small_single_auto: got %0d beats %0d done, expected %0d/1", q1.size(), done_cnt1, N1);
    end
  endtask

  initial begin
    rst0_n = 1'b0; auto_en0 = 1'b0; trig0 = 1'b0; ready0 = 1'b1; dump_cycle0 = '0; rnd0 = 1'b0;
    rst1_n = 1'b0; auto_en1 = 1'b0; trig1 = 1'b0; ready1 = 1'b1; dump_cycle1 = '0;
    for (int i = 0; i < NR0; i++) rf0[i] = '0;
    for (int i = 0; i < NM0; i++) mem0[i] = '0;
    for (int i = 0; i < NR1; i++) rf1[i] = '0;
    for (int i = 0; i < NM1; i++) mem1[i] = '0;
    clear0();
    test_reset();
    test_auto_dump();
    test_backpressure();
    test_trig_during_dump();
    test_reset_mid_dump();
    test_small();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
